// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined adder among NREQ requesters.
// Optional per-requester grant counters are enabled by defining ADD_SCHED_STATS_EN.
module adder_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [3:0]            inflight,
  output logic                  idle
`ifdef ADD_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]    stat_grants
`endif
);

  localparam int PTR_W  = $clog2(NREQ);
  localparam int STAGES = LAT + 1;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    return PTR_W'((int'(base) + off) % NREQ);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] id);
    return (id == PTR_W'(NREQ - 1)) ? '0 : id + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0] rr_ptr_r;
  logic             found_s;
  logic [PTR_W-1:0] gnt_id_s;
  logic             grant_s;
  logic             capture_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  logic [WIDTH-1:0] add_a_r;
  logic [WIDTH-1:0] add_b_r;
  logic [STAGES-1:0] tag_vld_r;
  logic [PTR_W-1:0]  tag_id_r [STAGES];
  logic [NREQ-1:0]   rsp_valid_r;
  logic [WIDTH-1:0]  rsp_sum_r;
  logic              rsp_cout_r;
  logic [3:0]        inflight_r;

  // Search downward so the entry closest to rr_ptr wins without a found-flag chain.
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      found_s  = found_s | req_valid[wrap_idx(rr_ptr_r, k)];
      gnt_id_s = req_valid[wrap_idx(rr_ptr_r, k)] ? wrap_idx(rr_ptr_r, k) : gnt_id_s;
    end
  end

  // Grant qualification and the ready one-hot; no grant while reset is held.
  always_comb begin
    grant_s = rst_n & en & ~flush & found_s;
    if (grant_s) begin
      req_ready = onehot(gnt_id_s);
    end else begin
      req_ready = '0;
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    sel_a_s = req_a[int'(gnt_id_s)*WIDTH +: WIDTH];
    sel_b_s = req_b[int'(gnt_id_s)*WIDTH +: WIDTH];
  end

  assign capture_s = tag_vld_r[LAT] & ~flush;

  // Round-robin pointer advances past the winner only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (grant_s) begin
      rr_ptr_r <= next_ptr(gnt_id_s);
    end
  end

  // Operand registers feeding the shared adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a_r <= '0;
      add_b_r <= '0;
    end else if (grant_s) begin
      add_a_r <= sel_a_s;
      add_b_r <= sel_b_s;
    end
  end

  // Tag valid bits; flush drops every in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
    end else if (flush) begin
      tag_vld_r <= '0;
    end else begin
      tag_vld_r <= {tag_vld_r[STAGES-2:0], grant_s};
    end
  end

  // Tag requester ids travel alongside the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        tag_id_r[s] <= '0;
      end
    end else begin
      tag_id_r[0] <= gnt_id_s;
      for (int s = 1; s < STAGES; s++) begin
        tag_id_r[s] <= tag_id_r[s-1];
      end
    end
  end

  // Response capture: the last tag stage lines up with the adder result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_sum_r   <= '0;
      rsp_cout_r  <= 1'b0;
    end else if (capture_s) begin
      rsp_valid_r <= onehot(tag_id_r[LAT]);
      rsp_sum_r   <= add_sum;
      rsp_cout_r  <= add_cout;
    end else begin
      rsp_valid_r <= '0;
    end
  end

  // Occupancy counts an op from grant until its result is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 4'd0;
    end else if (flush) begin
      inflight_r <= 4'd0;
    end else begin
      case ({grant_s, capture_s})
        2'b10:   inflight_r <= inflight_r + 4'd1;
        2'b01:   inflight_r <= inflight_r - 4'd1;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign inflight  = inflight_r;
  assign idle      = (inflight_r == 4'd0) && (req_valid == '0);

`ifdef ADD_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] grant_cnt_r [NREQ];

  // Saturating grant counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt_r[i] <= 16'd0;
      end
    end else if (grant_s) begin
      grant_cnt_r[gnt_id_s] <= sat_inc16(grant_cnt_r[gnt_id_s]);
    end
  end

  // Pack the counters onto the flat output.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_grants[i*16 +: 16] = grant_cnt_r[i];
    end
  end
`endif

endmodule
